// File: rtl/formula_inv_pkg.sv
// Shared widths and types for the formula inverse pipe.
//   W_ARG  : width of full-range operands and squares (32)
//   W_ROOT : width of square-root-range values fed to the squarers (16)
package formula_inv_pkg;
    localparam int W_ARG  = 32;
    localparam int W_ROOT = 16;

    typedef logic [W_ARG-1:0]  arg_t;
    typedef logic [W_ROOT-1:0] root_t;
endpackage

// File: rtl/formula_2_inverse_pipe_square_pipe.sv
// Pipelined shift-and-add squarer, y = x*x with latency N_STAGES.
// Stage s adds the partial products for multiplier bits
// [s*BPS +: BPS] (BPS = 16/N_STAGES), so N_STAGES must divide 16.
//   clk, rst     : clock, synchronous active-high reset
//   x_vld, x     : operand
//   y_vld, y     : square, held between valid results, reset 0
module square_pipe
    import formula_inv_pkg::*;
#(
    parameter int N_STAGES = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  x_vld,
    input  root_t x,
    output logic  y_vld,
    output arg_t  y
);
    localparam int BPS = W_ROOT / N_STAGES;

    logic [N_STAGES:1] vld_pipe;
    arg_t [N_STAGES:1] acc_pipe;

    // Add this stage's slice of partial products onto the running sum.
    function automatic arg_t pp_add(input arg_t acc, input root_t m, input int stage);
        arg_t  sum;
        root_t sh;
        sum = acc;
        for (int j = 0; j < BPS; j++) begin
            sh = m >> (stage * BPS + j);
            if (sh[0]) sum = sum + (arg_t'(m) << (stage * BPS + j));
        end
        return sum;
    endfunction

    if (N_STAGES == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_pipe <= '0;
                acc_pipe <= '0;
            end else begin
                vld_pipe[1] <= x_vld;
                if (x_vld) acc_pipe[1] <= pp_add('0, x, 0);
            end
        end
    end else begin : g_multi
        // The multiplicand rides along every stage except the last one.
        root_t [N_STAGES-1:1] x_pipe;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_pipe <= '0;
                acc_pipe <= '0;
                x_pipe   <= '0;
            end else begin
                vld_pipe[1] <= x_vld;
                if (x_vld) begin
                    acc_pipe[1] <= pp_add('0, x, 0);
                    x_pipe[1]   <= x;
                end
                for (int s = 2; s <= N_STAGES; s++) begin
                    vld_pipe[s] <= vld_pipe[s-1];
                    if (vld_pipe[s-1]) acc_pipe[s] <= pp_add(acc_pipe[s-1], x_pipe[s-1], s - 1);
                end
                for (int s = 2; s < N_STAGES; s++) begin
                    if (vld_pipe[s-1]) x_pipe[s] <= x_pipe[s-1];
                end
            end
        end
    end

    assign y_vld = vld_pipe[N_STAGES];
    assign y     = acc_pipe[N_STAGES];
endmodule

// File: rtl/shift_register_with_valid.sv
// Valid-qualified delay line: each data stage loads only when the stage
// feeding it is valid, otherwise it holds. The valid bits always shift.
//   clk, rst          : clock, synchronous active-high reset
//   in_vld, in_data   : input sample
//   out_vld, out_data : same sample DEPTH cycles later
module shift_register_with_valid #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data
);
    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][WIDTH-1:0] data_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            if (in_vld) data_pipe[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign out_vld  = vld_pipe[DEPTH-1];
    assign out_data = data_pipe[DEPTH-1];
endmodule

// File: rtl/formula_2_inverse_pipe.sv
// Pipelined inverse of the 3-level isqrt formula pipe:
//   c = ((r^2 - a)^2 - b)^2, with err flagging any underflowing
//   subtraction or a squarer operand that does not fit in 16 bits.
// One (r, a, b) accepted per clock, result after LAT = 3*SQ_STAGES+2.
//   clk, rst         : clock, synchronous active-high reset
//   arg_vld, r, a, b : operands
//   res_vld, res, err: reconstructed c (0 when err), held while res_vld=0
module formula_2_inverse_pipe
    import formula_inv_pkg::*;
#(
    parameter int SQ_STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    input  logic [15:0] r,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        res_vld,
    output logic [31:0] res,
    output logic        err
);
    localparam int LAT     = 3 * SQ_STAGES + 2;
    // b is consumed by the second glue stage: two squarers plus t1 reg earlier.
    localparam int B_DEPTH = LAT - SQ_STAGES - 1;

    logic  sq1_vld, sq2_vld, sq3_vld, a_vld, b_vld, e1_vld, e2_vld;
    arg_t  sq1, sq2, sq3, a_d, b_d;
    logic  e1_d, e2_d;
    logic  t1_vld, t2_vld, e1, e2;
    root_t t1, t2;
    arg_t  d1, d2;

    square_pipe #(.N_STAGES(SQ_STAGES)) u_sq1 (
        .clk(clk), .rst(rst), .x_vld(arg_vld), .x(r), .y_vld(sq1_vld), .y(sq1));

    shift_register_with_valid #(.WIDTH(W_ARG), .DEPTH(SQ_STAGES)) u_a_dly (
        .clk(clk), .rst(rst), .in_vld(arg_vld), .in_data(a), .out_vld(a_vld), .out_data(a_d));

    shift_register_with_valid #(.WIDTH(W_ARG), .DEPTH(B_DEPTH)) u_b_dly (
        .clk(clk), .rst(rst), .in_vld(arg_vld), .in_data(b), .out_vld(b_vld), .out_data(b_d));

    // Wrapped differences; the upper half being nonzero means the value
    // cannot be squared in 16 bits. Underflow is caught by the compare.
    assign d1 = sq1 - a_d;
    assign d2 = sq2 - b_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            t1_vld <= 1'b0;
            t1     <= '0;
            e1     <= 1'b0;
            t2_vld <= 1'b0;
            t2     <= '0;
            e2     <= 1'b0;
        end else begin
            t1_vld <= sq1_vld & a_vld;
            if (sq1_vld & a_vld) begin
                t1 <= d1[W_ROOT-1:0];
                e1 <= (a_d > sq1) | (|d1[W_ARG-1:W_ROOT]);
            end
            t2_vld <= sq2_vld & b_vld & e1_vld;
            if (sq2_vld & b_vld & e1_vld) begin
                t2 <= d2[W_ROOT-1:0];
                e2 <= e1_d | (b_d > sq2) | (|d2[W_ARG-1:W_ROOT]);
            end
        end
    end

    square_pipe #(.N_STAGES(SQ_STAGES)) u_sq2 (
        .clk(clk), .rst(rst), .x_vld(t1_vld), .x(t1), .y_vld(sq2_vld), .y(sq2));

    // Error bits bypass the squarers in their own delay lines.
    shift_register_with_valid #(.WIDTH(1), .DEPTH(SQ_STAGES)) u_e1_dly (
        .clk(clk), .rst(rst), .in_vld(t1_vld), .in_data(e1), .out_vld(e1_vld), .out_data(e1_d));

    square_pipe #(.N_STAGES(SQ_STAGES)) u_sq3 (
        .clk(clk), .rst(rst), .x_vld(t2_vld), .x(t2), .y_vld(sq3_vld), .y(sq3));

    shift_register_with_valid #(.WIDTH(1), .DEPTH(SQ_STAGES)) u_e2_dly (
        .clk(clk), .rst(rst), .in_vld(t2_vld), .in_data(e2), .out_vld(e2_vld), .out_data(e2_d));

    // Both sources are valid-gated registers, so the outputs hold between results.
    assign res_vld = sq3_vld & e2_vld;
    assign err     = e2_d;
    assign res     = e2_d ? '0 : sq3;
endmodule

// File: tb/tb_formula_2_inverse_pipe.sv
module tb_formula_2_inverse_pipe;
    localparam int LAT  = 14;
    localparam int LAT1 = 5;
    localparam int LAT8 = 26;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, arg_vld;
    logic [15:0] r;
    logic [31:0] a, b;
    logic        res_vld, err, res_vld1, err1, res_vld8, err8;
    logic [31:0] res, res1, res8;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_in = 0;
    int   n_out = 0;
    exp_t sb[$];
    exp_t mon_e;

    formula_2_inverse_pipe #(.SQ_STAGES(4)) dut (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .r(r), .a(a), .b(b),
        .res_vld(res_vld), .res(res), .err(err));
    formula_2_inverse_pipe #(.SQ_STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .r(r), .a(a), .b(b),
        .res_vld(res_vld1), .res(res1), .err(err1));
    formula_2_inverse_pipe #(.SQ_STAGES(8)) dut8 (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .r(r), .a(a), .b(b),
        .res_vld(res_vld8), .res(res8), .err(err8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: evaluate c = ((r^2 - a)^2 - b)^2 in wide arithmetic.
    function automatic exp_t ref_model(input logic [15:0] rr, input logic [31:0] aa,
                                       input logic [31:0] bb, input int due);
        longint unsigned s1, t1, s2, t2;
        exp_t e;
        e.due = due; e.err = 1'b0; e.res = '0;
        s1 = longint'(rr) * longint'(rr);
        if (longint'(aa) > s1) e.err = 1'b1;
        else begin
            t1 = s1 - longint'(aa);
            if (t1 >= 65536) e.err = 1'b1;
            else begin
                s2 = t1 * t1;
                if (longint'(bb) > s2) e.err = 1'b1;
                else begin
                    t2 = s2 - longint'(bb);
                    if (t2 >= 65536) e.err = 1'b1;
                    else e.res = 32'(t2 * t2);
                end
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] rr, input logic [31:0] aa,
                         input logic [31:0] bb);
        @(posedge clk); #2;
        arg_vld = v; r = rr; a = aa; b = bb;
        if (v) begin
            sb.push_back(ref_model(rr, aa, bb, cyc + LAT));
            n_in++;
        end
    endtask

    // Operands whose chain never errors: pick t1, t2 in range, derive a, b.
    task automatic drive_legal();
        int unsigned rr, t1, t2, t1max, t2max;
        longint unsigned s1, s2;
        rr    = $urandom_range(0, 65535);
        s1    = longint'(rr) * longint'(rr);
        t1max = (s1 < 65535) ? 32'(s1) : 32'd65535;
        t1    = $urandom_range(0, t1max);
        s2    = longint'(t1) * longint'(t1);
        t2max = (s2 < 65535) ? 32'(s2) : 32'd65535;
        t2    = $urandom_range(0, t2max);
        drive(1'b1, 16'(rr), 32'(s1 - t1), 32'(s2 - t2));
    endtask

    // Single arg, then check the pulse lands exactly LAT cycles later.
    task automatic directed(input string tag, input logic [15:0] rr, input logic [31:0] aa,
                            input logic [31:0] bb, input logic [31:0] exp_res, input logic exp_err);
        int due;
        drive(1'b1, rr, aa, bb);
        due = cyc + LAT;
        for (int k = 0; k < LAT + 2; k++) begin
            @(posedge clk); #2;
            arg_vld = 1'b0;
            check({tag, "_vld"}, 32'(res_vld), 32'(cyc == due));
            if (cyc == due) begin
                check({tag, "_res"}, res, exp_res);
                check({tag, "_err"}, 32'(err), 32'(exp_err));
            end
        end
    endtask

    task automatic reset_cycles(input int n);
        @(posedge clk); #2;
        arg_vld = 1'b0; rst = 1'b1;
        sb.delete(); n_in = 0; n_out = 0;
        repeat (n - 1) @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Scoreboard: every pulse must match the oldest pending arg at its due cycle.
    always @(posedge clk) begin
        #1;
        if (res_vld === 1'b1) begin
            checks++;
            assert (sb.size() != 0 && sb[0].due == cyc) else begin
                failures++;
                $error("FAIL res_vld_timing cyc=%0d observed=pulse expected=no_pulse", cyc);
            end
            if (sb.size() != 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                n_out++;
                checks++;
                assert (err === mon_e.err && res === mon_e.res) else begin
                    failures++;
                    $error("FAIL stream_data cyc=%0d observed=%0b/%0h expected=%0b/%0h",
                           cyc, err, res, mon_e.err, mon_e.res);
                end
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            assert (res_vld === 1'b1) else begin
                failures++;
                $error("FAIL missing_res_vld cyc=%0d observed=%0b expected=1", cyc, res_vld);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hr, hr1, hr8;
        logic        he, he1, he8;
        int          e0;
        rst = 1'b1; arg_vld = 1'b0; r = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_vld", 32'(res_vld), 0);
        check("rst_res", res, 0);
        check("rst_err", 32'(err), 0);
        check("rst_vld1", 32'(res_vld1), 0);
        check("rst_vld8", 32'(res_vld8), 0);
        rst = 1'b0;

        directed("t1_basic", 16'd5, 32'd20, 32'd24, 32'd1, 1'b0);
        directed("t2_uflow1", 16'd3, 32'd10, 32'd0, 32'd0, 1'b1);
        directed("t3_big_t1", 16'd300, 32'd0, 32'd0, 32'd0, 1'b1);
        directed("zero", 16'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        directed("t1_max", 16'd256, 32'd1, 32'd4294836222, 32'd9, 1'b0);
        directed("t1_2p16", 16'd256, 32'd0, 32'd0, 32'd0, 1'b1);
        directed("uflow2", 16'd5, 32'd20, 32'd26, 32'd0, 1'b1);
        directed("big_t2", 16'd256, 32'd1, 32'd0, 32'd0, 1'b1);

        // 64 back-to-back legal vectors, then bubbly mixed stream.
        for (int i = 0; i < 64; i++) drive_legal();
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 2) == 0) drive(1'b0, 16'($urandom), $urandom, $urandom);
            else if ($urandom_range(0, 1) == 0) drive_legal();
            else drive(1'b1, 16'($urandom_range(0, 400)), $urandom_range(0, 90000), $urandom_range(0, 1000));
        end
        drive(1'b0, '0, '0, '0);
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        #2;
        check("stream_drain", sb.size(), 0);
        check("stream_count", n_out, n_in);

        // Reset mid-stream: in-flight args must vanish.
        for (int i = 0; i < 20; i++) drive_legal();
        @(posedge clk); #2;
        arg_vld = 1'b0; rst = 1'b1;
        sb.delete(); n_in = 0; n_out = 0;
        @(posedge clk); #2;
        check("rst_mid_vld", 32'(res_vld), 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) drive(1'b0, 16'($urandom), $urandom, $urandom);
        directed("post_rst", 16'd5, 32'd20, 32'd24, 32'd1, 1'b0);

        // Idle with toggling operands: outputs hold.
        hr = res; he = err;
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 16'($urandom), $urandom, $urandom);
            check("idle_vld", 32'(res_vld), 0);
            check("idle_res", res, hr);
            check("idle_err", 32'(err), 32'(he));
        end

        // Other depths: exact latency, then hold under idle toggling.
        reset_cycles(2);
        drive(1'b1, 16'd5, 32'd20, 32'd24);
        e0 = cyc;
        for (int k = 0; k < LAT8 + 3; k++) begin
            @(posedge clk); #2;
            arg_vld = 1'b0;
            check("s1_vld", 32'(res_vld1), 32'(cyc == e0 + LAT1));
            check("s8_vld", 32'(res_vld8), 32'(cyc == e0 + LAT8));
            if (cyc == e0 + LAT1) begin
                check("s1_res", res1, 1);
                check("s1_err", 32'(err1), 0);
            end
            if (cyc == e0 + LAT8) begin
                check("s8_res", res8, 1);
                check("s8_err", 32'(err8), 0);
            end
        end
        hr1 = res1; he1 = err1; hr8 = res8; he8 = err8;
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 16'($urandom), $urandom, $urandom);
            check("idle1_vld", 32'(res_vld1), 0);
            check("idle1_res", res1, hr1);
            check("idle1_err", 32'(err1), 32'(he1));
            check("idle8_vld", 32'(res_vld8), 0);
            check("idle8_res", res8, hr8);
            check("idle8_err", 32'(err8), 32'(he8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
